// File: rtl/hand_centroid.sv
// hand_centroid
//   Per-frame centroid tracker for the two gloved hands. Each qualified pixel
//   flagged as left and/or right hand adds its coordinates to that hand's sums
//   and bumps its pixel count. On frame_end the sums are snapshotted, and one
//   shared restoring divider then computes the four means: left x, left y,
//   right x, right y. The 16-bit results are published together with
//   per-hand "found" flags and a one-cycle coords_valid pulse.
//
//   Optional feature macro: CENTROID_SMOOTH_EN
//     When defined, a hand found in both this frame and the previous frame
//     loads (3*old + new) >> 2 instead of the raw quotient.
//
// Ports
//   clock        in   1   system clock
//   reset        in   1   synchronous, active-high
//   pixel_valid  in   1   hcount/vcount/hits qualify this cycle
//   hcount       in  11   pixel x
//   vcount       in  10   pixel y
//   left_hit     in   1   pixel classified as left hand
//   right_hit    in   1   pixel classified as right hand
//   frame_end    in   1   one-cycle pulse after the last active pixel
//   x1, y1       out 16   left-hand centroid
//   x2, y2       out 16   right-hand centroid
//   left_found   out  1   left count >= MIN_PIXELS in the last completed frame
//   right_found  out  1   right count >= MIN_PIXELS in the last completed frame
//   coords_valid out  1   one-cycle pulse when coordinates and flags update
//   busy         out  1   high from LATCH through WRITE
module hand_centroid #(
  parameter int unsigned H_ACTIVE   = 1024,
  parameter int unsigned V_ACTIVE   = 768,
  parameter int unsigned MIN_PIXELS = 64,
  parameter int unsigned ACC_W      = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixel_valid,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        left_hit,
  input  logic        right_hit,
  input  logic        frame_end,
  output logic [15:0] x1,
  output logic [15:0] y1,
  output logic [15:0] x2,
  output logic [15:0] y2,
  output logic        left_found,
  output logic        right_found,
  output logic        coords_valid,
  output logic        busy
);

  localparam int unsigned BIT_W = $clog2(ACC_W);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_DIV, S_WRITE} state_t;

  state_t state, state_next;

  logic do_latch, do_div, do_write;

  // Running accumulators for the frame currently being received.
  logic [ACC_W-1:0] acc_lsx, acc_lsy, acc_lcnt, acc_rsx, acc_rsy, acc_rcnt;
  logic [ACC_W-1:0] nxt_lsx, nxt_lsy, nxt_lcnt, nxt_rsx, nxt_rsy, nxt_rcnt;

  // Snapshot of the closed frame, stable for the whole division sequence.
  logic [ACC_W-1:0] snap_lsx, snap_lsy, snap_lcnt, snap_rsx, snap_rsy, snap_rcnt;

  // Divider datapath.
  logic [BIT_W-1:0] bit_cnt;
  logic [1:0]       div_idx;
  logic [ACC_W-1:0] quot, rem;
  logic [ACC_W-1:0] dividend, divisor;
  logic [ACC_W-1:0] cur_q, cur_r, diff, quot_next, rem_next;
  logic [ACC_W:0]   trial;
  logic             ge, last_bit, div_done;
  logic [15:0]      q_lx, q_ly, q_rx, q_ry;

  logic             pix_ok, add_l, add_r;
  logic [ACC_W-1:0] x_ext, y_ext;
  logic             l_found_new, r_found_new;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (frame_end) state_next = S_LATCH;
      S_LATCH: state_next = S_DIV;
      S_DIV:   if (div_done) state_next = S_WRITE;
      S_WRITE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    do_latch = (state == S_LATCH);
    do_div   = (state == S_DIV);
    do_write = (state == S_WRITE);
  end

  // ---------------------------------------------------------- accumulate
  // Out-of-raster coordinates are treated as blanking and never counted.
  always_comb begin
    pix_ok = pixel_valid && (32'(hcount) < H_ACTIVE) && (32'(vcount) < V_ACTIVE);
    add_l  = pix_ok && left_hit;
    add_r  = pix_ok && right_hit;
    x_ext  = ACC_W'(hcount);
    y_ext  = ACC_W'(vcount);
  end

  // During LATCH the accumulators restart from zero, so a pixel arriving in
  // that same cycle lands in the next frame's totals.
  always_comb begin
    nxt_lsx  = do_latch ? '0 : acc_lsx;
    nxt_lsy  = do_latch ? '0 : acc_lsy;
    nxt_lcnt = do_latch ? '0 : acc_lcnt;
    nxt_rsx  = do_latch ? '0 : acc_rsx;
    nxt_rsy  = do_latch ? '0 : acc_rsy;
    nxt_rcnt = do_latch ? '0 : acc_rcnt;
    if (add_l) begin
      nxt_lsx = nxt_lsx + x_ext;
      nxt_lsy = nxt_lsy + y_ext;
      if (nxt_lcnt != '1) nxt_lcnt = nxt_lcnt + 1'b1;
    end
    if (add_r) begin
      nxt_rsx = nxt_rsx + x_ext;
      nxt_rsy = nxt_rsy + y_ext;
      if (nxt_rcnt != '1) nxt_rcnt = nxt_rcnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_lsx  <= '0;
      acc_lsy  <= '0;
      acc_lcnt <= '0;
      acc_rsx  <= '0;
      acc_rsy  <= '0;
      acc_rcnt <= '0;
    end else begin
      acc_lsx  <= nxt_lsx;
      acc_lsy  <= nxt_lsy;
      acc_lcnt <= nxt_lcnt;
      acc_rsx  <= nxt_rsx;
      acc_rsy  <= nxt_rsy;
      acc_rcnt <= nxt_rcnt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      snap_lsx  <= '0;
      snap_lsy  <= '0;
      snap_lcnt <= '0;
      snap_rsx  <= '0;
      snap_rsy  <= '0;
      snap_rcnt <= '0;
    end else if (do_latch) begin
      snap_lsx  <= acc_lsx;
      snap_lsy  <= acc_lsy;
      snap_lcnt <= acc_lcnt;
      snap_rsx  <= acc_rsx;
      snap_rsy  <= acc_rsy;
      snap_rcnt <= acc_rcnt;
    end
  end

  // ------------------------------------------------------------- divider
  // Restoring division, MSB first. On the first bit of each slot the
  // dividend is taken straight from the snapshot and the remainder from zero,
  // so no separate load cycle is needed between the four divisions. A zero
  // divisor just yields all-ones; that slot is discarded by the found check.
  always_comb begin
    case (div_idx)
      2'd0:    begin dividend = snap_lsx; divisor = snap_lcnt; end
      2'd1:    begin dividend = snap_lsy; divisor = snap_lcnt; end
      2'd2:    begin dividend = snap_rsx; divisor = snap_rcnt; end
      default: begin dividend = snap_rsy; divisor = snap_rcnt; end
    endcase
    cur_q     = (bit_cnt == '0) ? dividend : quot;
    cur_r     = (bit_cnt == '0) ? '0 : rem;
    trial     = {cur_r, cur_q[ACC_W-1]};
    ge        = (trial >= {1'b0, divisor});
    diff      = trial[ACC_W-1:0] - divisor;
    rem_next  = ge ? diff : trial[ACC_W-1:0];
    quot_next = {cur_q[ACC_W-2:0], ge};
    last_bit  = (bit_cnt == BIT_W'(ACC_W - 1));
    div_done  = last_bit && (div_idx == 2'd3);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt <= '0;
      div_idx <= '0;
      quot    <= '0;
      rem     <= '0;
      q_lx    <= '0;
      q_ly    <= '0;
      q_rx    <= '0;
      q_ry    <= '0;
    end else if (do_div) begin
      quot    <= quot_next;
      rem     <= rem_next;
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      if (last_bit) begin
        div_idx <= div_idx + 2'd1;
        case (div_idx)
          2'd0:    q_lx <= quot_next[15:0];
          2'd1:    q_ly <= quot_next[15:0];
          2'd2:    q_rx <= quot_next[15:0];
          default: q_ry <= quot_next[15:0];
        endcase
      end
    end else begin
      bit_cnt <= '0;
      div_idx <= '0;
    end
  end

  // -------------------------------------------------------------- output
  always_comb begin
    l_found_new = (snap_lcnt >= ACC_W'(MIN_PIXELS));
    r_found_new = (snap_rcnt >= ACC_W'(MIN_PIXELS));
  end

`ifdef CENTROID_SMOOTH_EN
  // Exponential smoothing, weight 1/4 on the new sample; 18 bits cannot overflow.
  function automatic logic [15:0] blend(input logic [15:0] old_v, input logic [15:0] new_v);
    logic [17:0] t;
    t = 18'(old_v) * 18'd3 + 18'(new_v);
    t = t >> 2;
    return t[15:0];
  endfunction
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      x1           <= '0;
      y1           <= '0;
      x2           <= '0;
      y2           <= '0;
      left_found   <= 1'b0;
      right_found  <= 1'b0;
      coords_valid <= 1'b0;
    end else begin
      coords_valid <= do_write;
      if (do_write) begin
        left_found  <= l_found_new;
        right_found <= r_found_new;
`ifdef CENTROID_SMOOTH_EN
        if (l_found_new) begin
          x1 <= left_found ? blend(x1, q_lx) : q_lx;
          y1 <= left_found ? blend(y1, q_ly) : q_ly;
        end
        if (r_found_new) begin
          x2 <= right_found ? blend(x2, q_rx) : q_rx;
          y2 <= right_found ? blend(y2, q_ry) : q_ry;
        end
`else
        if (l_found_new) begin
          x1 <= q_lx;
          y1 <= q_ly;
        end
        if (r_found_new) begin
          x2 <= q_rx;
          y2 <= q_ry;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_hand_centroid.sv
// tb_hand_centroid
//   Directed bench for hand_centroid. A frame-level model (sums, counts,
//   integer division, countdown to publication) predicts every output each
//   cycle; a compare process checks the DUT on every falling edge, and the
//   directed scenarios add literal expectations that pin the model.
module tb_hand_centroid;

  localparam int ACC_W      = 32;
  localparam int MIN_PIXELS = 64;
  localparam int H_ACTIVE   = 1024;
  localparam int V_ACTIVE   = 768;
  localparam int LAT        = 4 * ACC_W + 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pixel_valid = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        left_hit = 1'b0;
  logic        right_hit = 1'b0;
  logic        frame_end = 1'b0;
  logic [15:0] x1, y1, x2, y2;
  logic        left_found, right_found, coords_valid, busy;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cv_pulses    = 0;

  always #5 clock = ~clock;

  hand_centroid #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .MIN_PIXELS(MIN_PIXELS), .ACC_W(ACC_W)
  ) dut (
    .clock(clock), .reset(reset), .pixel_valid(pixel_valid),
    .hcount(hcount), .vcount(vcount), .left_hit(left_hit), .right_hit(right_hit),
    .frame_end(frame_end), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .left_found(left_found), .right_found(right_found),
    .coords_valid(coords_valid), .busy(busy)
  );

  // ------------------------------------------------------------ model
  longint m_lsx, m_lsy, m_lcnt, m_rsx, m_rsy, m_rcnt;
  longint s_lsx, s_lsy, s_lcnt, s_rsx, s_rsy, s_rcnt;
  int     countdown = 0;
  logic [15:0] e_x1, e_y1, e_x2, e_y2;
  logic        e_lf, e_rf, e_cv;
  bit          model_ready = 0;

  function automatic logic [15:0] smooth(input logic [15:0] old_v, input logic [15:0] new_v,
                                         input logic prev_found);
`ifdef CENTROID_SMOOTH_EN
    int v;
    if (!prev_found) return new_v;
    v = (3 * int'(old_v) + int'(new_v)) / 4;
    return 16'(v);
`else
    return new_v;
`endif
  endfunction

  function automatic logic [15:0] mean16(input longint s, input longint c);
    longint q;
    q = s / c;
    return 16'(q % 65536);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_lsx = 0; m_lsy = 0; m_lcnt = 0; m_rsx = 0; m_rsy = 0; m_rcnt = 0;
      countdown = 0;
      e_x1 = 0; e_y1 = 0; e_x2 = 0; e_y2 = 0;
      e_lf = 0; e_rf = 0; e_cv = 0;
      model_ready = 1;
    end else begin
      e_cv = 0;
      if (pixel_valid && hcount < H_ACTIVE && vcount < V_ACTIVE) begin
        if (left_hit)  begin m_lsx += hcount; m_lsy += vcount; m_lcnt++; end
        if (right_hit) begin m_rsx += hcount; m_rsy += vcount; m_rcnt++; end
      end
      if (countdown != 0) begin
        countdown--;
        if (countdown == 0) begin
          if (s_lcnt >= MIN_PIXELS) begin
            e_x1 = smooth(e_x1, mean16(s_lsx, s_lcnt), e_lf);
            e_y1 = smooth(e_y1, mean16(s_lsy, s_lcnt), e_lf);
          end
          if (s_rcnt >= MIN_PIXELS) begin
            e_x2 = smooth(e_x2, mean16(s_rsx, s_rcnt), e_rf);
            e_y2 = smooth(e_y2, mean16(s_rsy, s_rcnt), e_rf);
          end
          e_lf = (s_lcnt >= MIN_PIXELS);
          e_rf = (s_rcnt >= MIN_PIXELS);
          e_cv = 1;
        end
      end else if (frame_end) begin
        // The closing frame includes this edge's pixel; the next pixel is fresh.
        s_lsx = m_lsx; s_lsy = m_lsy; s_lcnt = m_lcnt;
        s_rsx = m_rsx; s_rsy = m_rsy; s_rcnt = m_rcnt;
        m_lsx = 0; m_lsy = 0; m_lcnt = 0; m_rsx = 0; m_rsy = 0; m_rcnt = 0;
        countdown = LAT;
      end
    end
  end

  // ------------------------------------------------------------ checks
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (coords_valid === 1'b1) cv_pulses++;
    if (model_ready) begin
      checkOutput("x1", 32'(x1), 32'(e_x1));
      checkOutput("y1", 32'(y1), 32'(e_y1));
      checkOutput("x2", 32'(x2), 32'(e_x2));
      checkOutput("y2", 32'(y2), 32'(e_y2));
      checkOutput("left_found", 32'(left_found), 32'(e_lf));
      checkOutput("right_found", 32'(right_found), 32'(e_rf));
      checkOutput("coords_valid", 32'(coords_valid), 32'(e_cv));
      checkOutput("busy", 32'(busy), 32'(countdown != 0));
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic applyStimulus(input int x, input int y, input bit l, input bit r);
    @(negedge clock);
    pixel_valid = 1'b1;
    hcount      = 11'(x);
    vcount      = 10'(y);
    left_hit    = l;
    right_hit   = r;
  endtask

  task automatic block(input int x0, input int y0, input int w, input int h,
                       input bit l, input bit r);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        applyStimulus(x0 + xx, y0 + yy, l, r);
  endtask

  task automatic repeatPixel(input int x, input int y, input int n, input bit l, input bit r);
    for (int i = 0; i < n; i++) applyStimulus(x, y, l, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      pixel_valid = 1'b0;
      left_hit    = 1'b0;
      right_hit   = 1'b0;
    end
  endtask

  // Returns on the falling edge right after the edge that samples frame_end.
  task automatic pulseFrameEnd();
    @(negedge clock);
    pixel_valid = 1'b0;
    left_hit    = 1'b0;
    right_hit   = 1'b0;
    frame_end   = 1'b1;
    @(negedge clock);
    frame_end   = 1'b0;
  endtask

  task automatic waitValid(output int k);
    k = 0;
    while (coords_valid !== 1'b1 && k < LAT + 100) begin
      @(negedge clock);
      k++;
    end
    if (coords_valid !== 1'b1) checkOutput("wait_coords_valid", 32'(coords_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int pulses_before;

    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("rst_x1", 32'(x1), 0);
    checkOutput("rst_y2", 32'(y2), 0);
    checkOutput("rst_found", 32'({left_found, right_found}), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_cv", 32'(coords_valid), 0);
    reset = 1'b0;

    // Left 10x10 block at x 100..109, y 600..609
    block(100, 600, 10, 10, 1'b1, 1'b0);
    pulseFrameEnd();
    checkOutput("busy_after_fe", 32'(busy), 1);
    waitValid(k);
    checkOutput("latency", 32'(k), 32'(LAT));
    checkOutput("t1_x1", 32'(x1), 104);
    checkOutput("t1_y1", 32'(y1), 604);
    checkOutput("t1_lf", 32'(left_found), 1);
    checkOutput("t1_rf", 32'(right_found), 0);
    checkOutput("t1_x2", 32'(x2), 0);
    checkOutput("t1_y2", 32'(y2), 0);
    @(negedge clock);
    checkOutput("t1_busy_done", 32'(busy), 0);

    // Right 8x8 block centred on (900.5, 700.5), then a too-small 5x5 block
    block(897, 697, 8, 8, 1'b0, 1'b1);
    pulseFrameEnd();
    waitValid(k);
    checkOutput("t2_x2", 32'(x2), 900);
    checkOutput("t2_y2", 32'(y2), 700);
    checkOutput("t2_rf", 32'(right_found), 1);
    checkOutput("t2_lf", 32'(left_found), 0);
    checkOutput("t2_x1_held", 32'(x1), 104);
    block(10, 10, 5, 5, 1'b0, 1'b1);
    pulseFrameEnd();
    waitValid(k);
    checkOutput("t3_rf", 32'(right_found), 0);
    checkOutput("t3_x2_held", 32'(x2), 900);
    checkOutput("t3_y2_held", 32'(y2), 700);

    // Both hits on the same pixel, exactly MIN_PIXELS times
    repeatPixel(512, 700, 64, 1'b1, 1'b1);
    pulseFrameEnd();
    waitValid(k);
    checkOutput("t4_x1", 32'(x1), 512);
    checkOutput("t4_y1", 32'(y1), 700);
    checkOutput("t4_x2", 32'(x2), 512);
    checkOutput("t4_y2", 32'(y2), 700);
    checkOutput("t4_found", 32'({left_found, right_found}), 3);

    // Second frame_end while busy is ignored; its frame merges into the next
    repeatPixel(100, 100, 64, 1'b0, 1'b1);
    pulses_before = cv_pulses;
    pulseFrameEnd();
    repeatPixel(400, 500, 8, 1'b1, 1'b0);
    pulseFrameEnd();
    repeatPixel(600, 100, 56, 1'b1, 1'b0);
    idle(1);
    waitValid(k);
    checkOutput("t5_rf", 32'(right_found), 1);
    checkOutput("t5_lf", 32'(left_found), 0);
    idle(LAT + 20);
    checkOutput("t5_single_cv", 32'(cv_pulses - pulses_before), 1);
    pulseFrameEnd();
    waitValid(k);
    checkOutput("t5_x1_merged", 32'(x1), 575);
    checkOutput("t5_y1_merged", 32'(y1), 150);
    checkOutput("t5_lf_merged", 32'(left_found), 1);

    // Reset in the middle of the division
    block(100, 600, 10, 10, 1'b1, 1'b0);
    pulseFrameEnd();
    idle(50);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("t6_busy", 32'(busy), 0);
    checkOutput("t6_xy", 32'({x1, y1} | {x2, y2}), 0);
    checkOutput("t6_found", 32'({left_found, right_found}), 0);
    checkOutput("t6_cv", 32'(coords_valid), 0);
    reset = 1'b0;
    pulses_before = cv_pulses;
    idle(LAT + 20);
    checkOutput("t6_no_cv", 32'(cv_pulses - pulses_before), 0);
    block(100, 600, 10, 10, 1'b1, 1'b0);
    pulseFrameEnd();
    waitValid(k);
    checkOutput("t6_x1", 32'(x1), 104);
    checkOutput("t6_y1", 32'(y1), 604);
    checkOutput("t6_lf", 32'(left_found), 1);

    // Empty frame, then x1 sequence 100, 200, 200
    pulseFrameEnd();
    waitValid(k);
    checkOutput("t7_lf_empty", 32'(left_found), 0);
    checkOutput("t7_x1_held", 32'(x1), 104);
    repeatPixel(100, 50, 64, 1'b1, 1'b0);
    pulseFrameEnd();
    waitValid(k);
    checkOutput("t7_x1_a", 32'(x1), 100);
    repeatPixel(200, 50, 64, 1'b1, 1'b0);
    pulseFrameEnd();
    waitValid(k);
`ifdef CENTROID_SMOOTH_EN
    checkOutput("t7_x1_b", 32'(x1), 125);
`else
    checkOutput("t7_x1_b", 32'(x1), 200);
`endif
    repeatPixel(200, 50, 64, 1'b1, 1'b0);
    pulseFrameEnd();
    waitValid(k);
`ifdef CENTROID_SMOOTH_EN
    checkOutput("t7_x1_c", 32'(x1), 143);
`else
    checkOutput("t7_x1_c", 32'(x1), 200);
`endif
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
